// File: rtl/gat_load_ctrl_wrapper.sv
// GAT load controller wrapper.
// Merges the PS-side byte-addressed load ports into one registered core write bus.
// Sequences start/ready for each layer and pipelines feature readback from the core BRAM.
module gat_load_ctrl_wrapper #(
    parameter int TOP_WIDTH   = 32,
    parameter int NUM_CH      = 3,
    parameter int CH_ADDR_W   = 18,
    parameter int CH_DATA_W   = 20,
    parameter int FEAT_ADDR_W = 16,
    parameter int FEAT_WIDTH  = 32,
    parameter int CNT_W       = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            gat_layer,
    input  logic [TOP_WIDTH-1:0]            load_din,
    input  logic [NUM_CH-1:0]               load_ena,
    input  logic [NUM_CH-1:0]               load_wea,
    input  logic [NUM_CH*(CH_ADDR_W+2)-1:0] load_addra,
    input  logic [NUM_CH-1:0]               load_done,
    output logic [NUM_CH-1:0]               core_we,
    output logic [CH_ADDR_W-1:0]            core_addr,
    output logic [CH_DATA_W-1:0]            core_din,
    output logic                            core_layer,
    output logic                            core_start,
    input  logic                            core_ready,
    output logic                            gat_ready,
    output logic [TOP_WIDTH-1:0]            gat_debug_1,
    output logic [TOP_WIDTH-1:0]            gat_debug_2,
    input  logic [FEAT_ADDR_W+1:0]          feat_bram_addrb,
    output logic [FEAT_ADDR_W-1:0]          core_feat_addr,
    input  logic [FEAT_WIDTH-1:0]           core_feat_dout,
    output logic [FEAT_WIDTH-1:0]           feat_bram_dout
);

    localparam int BA_W = CH_ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CH-1:0]      core_we_q, core_we_d;
    logic [CH_ADDR_W-1:0]   core_addr_q, core_addr_d;
    logic [CH_DATA_W-1:0]   core_din_q, core_din_d;
    logic                   core_layer_q, core_layer_d;
    logic                   core_start_q, core_start_d;
    logic                   gat_ready_q, gat_ready_d;
    logic [NUM_CH-1:0]      done_mask_q, done_mask_d;
    logic [2:0]             err_q, err_d;
    // Per-channel tallies are not observable on any port, so only the total is kept.
    logic [CNT_W-1:0]       total_q, total_d;
    logic [FEAT_ADDR_W-1:0] core_feat_addr_q, core_feat_addr_d;
    logic [FEAT_WIDTH-1:0]  feat_bram_dout_q, feat_bram_dout_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] win_oh;
    logic [BA_W-1:0]   win_addr;
    logic              win_found;
    logic              wr_open;
    logic              accept;
    logic              collision;
    logic              misalign;
    logic              blocked;
    logic              clear_cnt;
    logic [CNT_W-1:0]  cnt_base;

    // Byte-lane and payload bits the core never sees.
    logic unused_bits;
    assign unused_bits = ^{feat_bram_addrb[1:0], load_din[TOP_WIDTH-1:CH_DATA_W]};

    // Write arbitration: lowest valid channel wins, misaligned winner is dropped.
    always_comb begin
        req       = load_ena & load_wea;
        wr_open   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DONE);
        valid     = wr_open ? req : '0;
        win_found = 1'b0;
        win_oh    = '0;
        win_addr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (valid[i] && !win_found) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_addr  = load_addra[i*BA_W +: BA_W];
            end
        end
        misalign  = win_found && (win_addr[1:0] != 2'b00);
        accept    = win_found && (win_addr[1:0] == 2'b00);
        collision = win_found && ((valid & ~win_oh) != '0);
        blocked   = !wr_open && (req != '0);
    end

    // Next-state, status and output-register computation.
    always_comb begin
        state_d          = state_q;
        core_we_d        = accept ? win_oh : '0;
        core_addr_d      = accept ? win_addr[BA_W-1:2] : core_addr_q;
        core_din_d       = accept ? load_din[CH_DATA_W-1:0] : core_din_q;
        err_d            = err_q | {blocked, misalign, collision};
        done_mask_d      = done_mask_q;
        clear_cnt        = 1'b0;
        core_feat_addr_d = feat_bram_addrb[FEAT_ADDR_W+1:2];
        feat_bram_dout_d = core_feat_dout;

        case (state_q)
            S_IDLE: begin
                done_mask_d = done_mask_q | load_done;
                if (accept || (load_done != '0)) state_d = S_LOAD;
            end
            S_LOAD: begin
                done_mask_d = done_mask_q | load_done;
                if ((&done_mask_q) && (core_we_q == '0)) state_d = S_START;
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (core_ready) state_d = S_DONE;
            end
            S_DONE: begin
                // Any new write request opens the next load phase from a clean slate.
                if (req != '0) begin
                    state_d     = S_LOAD;
                    done_mask_d = '0;
                    clear_cnt   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_base     = clear_cnt ? '0 : total_q;
        total_d      = (accept && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
        core_start_d = (state_d == S_START);
        gat_ready_d  = (state_d == S_DONE);
        core_layer_d = (state_d == S_START) ? gat_layer : core_layer_q;
    end

    // All registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            core_we_q        <= '0;
            core_addr_q      <= '0;
            core_din_q       <= '0;
            core_layer_q     <= 1'b0;
            core_start_q     <= 1'b0;
            gat_ready_q      <= 1'b0;
            done_mask_q      <= '0;
            err_q            <= '0;
            total_q          <= '0;
            core_feat_addr_q <= '0;
            feat_bram_dout_q <= '0;
        end else begin
            state_q          <= state_d;
            core_we_q        <= core_we_d;
            core_addr_q      <= core_addr_d;
            core_din_q       <= core_din_d;
            core_layer_q     <= core_layer_d;
            core_start_q     <= core_start_d;
            gat_ready_q      <= gat_ready_d;
            done_mask_q      <= done_mask_d;
            err_q            <= err_d;
            total_q          <= total_d;
            core_feat_addr_q <= core_feat_addr_d;
            feat_bram_dout_q <= feat_bram_dout_d;
        end
    end

    assign core_we        = core_we_q;
    assign core_addr      = core_addr_q;
    assign core_din       = core_din_q;
    assign core_layer     = core_layer_q;
    assign core_start     = core_start_q;
    assign gat_ready      = gat_ready_q;
    assign core_feat_addr = core_feat_addr_q;
    assign feat_bram_dout = feat_bram_dout_q;
    assign gat_debug_1    = {state_q, err_q, done_mask_q, {(TOP_WIDTH-6-NUM_CH){1'b0}}};
    assign gat_debug_2    = {{(TOP_WIDTH-CNT_W){1'b0}}, total_q};

endmodule

// File: tb/tb_gat_load_ctrl_wrapper.sv
// Self-checking bench for gat_load_ctrl_wrapper (counter width reduced to 4 to reach saturation).
module tb_gat_load_ctrl_wrapper;

    logic        clk;
    logic        rst;
    logic        gat_layer;
    logic [31:0] load_din;
    logic [2:0]  load_ena;
    logic [2:0]  load_wea;
    logic [59:0] load_addra;
    logic [2:0]  load_done;
    logic [2:0]  core_we;
    logic [17:0] core_addr;
    logic [19:0] core_din;
    logic        core_layer;
    logic        core_start;
    logic        core_ready;
    logic        gat_ready;
    logic [31:0] gat_debug_1;
    logic [31:0] gat_debug_2;
    logic [17:0] feat_bram_addrb;
    logic [15:0] core_feat_addr;
    logic [31:0] core_feat_dout;
    logic [31:0] feat_bram_dout;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  we;
        logic [17:0] addr;
        logic [19:0] din;
    } exp_wr_t;
    exp_wr_t sb[$];

    typedef struct {
        logic [2:0]  ena;
        logic [2:0]  wea;
        logic [19:0] a0;
        logic [19:0] a1;
        logic [19:0] a2;
        logic [31:0] din;
        logic [2:0]  exp_we;
        logic [17:0] exp_addr;
        logic [19:0] exp_din;
        logic [2:0]  exp_err;
        logic [31:0] exp_cnt;
    } vec_t;

    logic [31:0] mem [16];

    gat_load_ctrl_wrapper #(
        .TOP_WIDTH(32), .NUM_CH(3), .CH_ADDR_W(18), .CH_DATA_W(20),
        .FEAT_ADDR_W(16), .FEAT_WIDTH(32), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .gat_layer(gat_layer), .load_din(load_din),
        .load_ena(load_ena), .load_wea(load_wea), .load_addra(load_addra),
        .load_done(load_done), .core_we(core_we), .core_addr(core_addr),
        .core_din(core_din), .core_layer(core_layer), .core_start(core_start),
        .core_ready(core_ready), .gat_ready(gat_ready), .gat_debug_1(gat_debug_1),
        .gat_debug_2(gat_debug_2), .feat_bram_addrb(feat_bram_addrb),
        .core_feat_addr(core_feat_addr), .core_feat_dout(core_feat_dout),
        .feat_bram_dout(feat_bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core feature BRAM model: one-cycle registered read.
    always @(posedge clk) core_feat_dout <= mem[core_feat_addr[3:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dbg1(input logic [2:0] st, input logic [2:0] er, input logic [2:0] dm);
        logic [31:0] v;
        v = {st, er, dm, 23'd0};
        return v;
    endfunction

    // Advance one clock and retire any core write against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (core_we != 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: core_we=%b with no expected write", core_we);
            end else begin
                exp_wr_t e;
                e = sb.pop_front();
                check("sb_we", 64'(core_we), 64'(e.we));
                check("sb_addr", 64'(core_addr), 64'(e.addr));
                check("sb_din", 64'(core_din), 64'(e.din));
            end
        end
    endtask

    task automatic drive_write(input logic [2:0] ch_oh, input logic [19:0] addr, input logic [31:0] din);
        load_ena   = ch_oh;
        load_wea   = ch_oh;
        load_addra = {addr, addr, addr};
        load_din   = din;
    endtask

    vec_t        vecs [6];
    logic [17:0] seq  [5];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 7);
        rst = 1'b1; gat_layer = 1'b0; load_din = '0; load_ena = '0; load_wea = '0;
        load_addra = '0; load_done = '0; core_ready = 1'b0; feat_bram_addrb = '0;

        vecs[0] = '{3'b010, 3'b010, 20'h0, 20'h10, 20'h0, 32'hFFFF_FFFF, 3'b010, 18'h4, 20'hFFFFF, 3'b000, 32'd1};
        vecs[1] = '{3'b101, 3'b101, 20'h20, 20'h0, 20'h30, 32'h0001_2345, 3'b001, 18'h8, 20'h12345, 3'b001, 32'd2};
        vecs[2] = '{3'b001, 3'b001, 20'h6, 20'h0, 20'h0, 32'h1111_1111, 3'b000, 18'h0, 20'h0, 3'b011, 32'd2};
        vecs[3] = '{3'b100, 3'b000, 20'h0, 20'h0, 20'h8, 32'h2222_2222, 3'b000, 18'h0, 20'h0, 3'b011, 32'd2};
        vecs[4] = '{3'b100, 3'b100, 20'h0, 20'h0, 20'hFFFFC, 32'hABCD_E123, 3'b100, 18'h3FFFF, 20'hDE123, 3'b011, 32'd3};
        vecs[5] = '{3'b110, 3'b110, 20'h0, 20'h8, 20'hC, 32'h0005_5555, 3'b010, 18'h2, 20'h55555, 3'b011, 32'd4};

        // T1: reset state
        repeat (3) tick();
        check("rst_core_we", 64'(core_we), 64'd0);
        check("rst_core_addr", 64'(core_addr), 64'd0);
        check("rst_core_din", 64'(core_din), 64'd0);
        check("rst_ctrl", 64'({core_layer, core_start, gat_ready}), 64'd0);
        check("rst_dbg1", 64'(gat_debug_1), 64'd0);
        check("rst_dbg2", 64'(gat_debug_2), 64'd0);
        check("rst_feat", 64'({core_feat_addr, feat_bram_dout}), 64'd0);
        rst = 1'b0;

        // core_ready before any START is ignored
        core_ready = 1'b1;
        tick(); tick();
        check("ready_ignored_state", 64'(gat_debug_1), 64'(dbg1(3'd0, 3'b000, 3'b000)));
        check("ready_ignored_gat", 64'(gat_ready), 64'd0);
        core_ready = 1'b0;

        // T2/T3: arbitration vector table
        for (int i = 0; i < 6; i++) begin
            load_ena   = vecs[i].ena;
            load_wea   = vecs[i].wea;
            load_addra = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
            load_din   = vecs[i].din;
            if (vecs[i].exp_we != 3'b000)
                sb.push_back('{vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_din});
            tick();
            check($sformatf("vec%0d_we", i), 64'(core_we), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d_err", i), 64'(gat_debug_1[28:26]), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_cnt", i), 64'(gat_debug_2), 64'(vecs[i].exp_cnt));
        end
        load_ena = '0; load_wea = '0;
        tick();
        check("idle_bus_we", 64'(core_we), 64'd0);
        check("load_dbg1", 64'(gat_debug_1), 64'(dbg1(3'd1, 3'b011, 3'b000)));

        // T4: done mask, start pulse, write in RUN, ready
        load_done = 3'b111; gat_layer = 1'b1;
        tick();
        check("mask_dbg1", 64'(gat_debug_1), 64'(dbg1(3'd1, 3'b011, 3'b111)));
        check("start_not_yet", 64'(core_start), 64'd0);
        tick();
        check("start_pulse", 64'(core_start), 64'd1);
        check("start_layer", 64'(core_layer), 64'd1);
        check("start_state", 64'(gat_debug_1[31:29]), 64'd2);
        load_done = 3'b000; gat_layer = 1'b0;
        tick();
        check("start_one_cycle", 64'(core_start), 64'd0);
        check("layer_held", 64'(core_layer), 64'd1);
        drive_write(3'b001, 20'h40, 32'h0000_9999);
        tick();
        check("run_write_dropped", 64'(core_we), 64'd0);
        check("run_dbg1", 64'(gat_debug_1), 64'(dbg1(3'd3, 3'b111, 3'b111)));
        check("run_cnt", 64'(gat_debug_2), 64'd4);
        load_ena = '0; load_wea = '0; core_ready = 1'b1;
        tick();
        check("gat_ready_set", 64'(gat_ready), 64'd1);
        core_ready = 1'b0;
        tick();
        check("gat_ready_held", 64'(gat_ready), 64'd1);
        check("done_dbg1", 64'(gat_debug_1), 64'(dbg1(3'd4, 3'b111, 3'b111)));

        // T5: new load from DONE
        drive_write(3'b001, 20'h0, 32'h0000_0077);
        sb.push_back('{3'b001, 18'h0, 20'h00077});
        tick();
        check("reload_gat_ready", 64'(gat_ready), 64'd0);
        check("reload_dbg1", 64'(gat_debug_1), 64'(dbg1(3'd1, 3'b111, 3'b000)));
        check("reload_cnt", 64'(gat_debug_2), 64'd1);

        // Counter saturation: 16 more writes push the total past 15
        for (int i = 0; i < 16; i++) begin
            drive_write(3'b001, 20'(i * 4), 32'(i + 32'h100));
            sb.push_back('{3'b001, 18'(i), 20'(i + 32'h100)});
            tick();
        end
        load_ena = '0; load_wea = '0;
        tick();
        check("cnt_saturated", 64'(gat_debug_2), 64'd15);

        // T6: pipelined feature readback
        seq[0] = 18'h0C; seq[1] = 18'h10; seq[2] = 18'h14; seq[3] = 18'h02; seq[4] = 18'h3C;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) feat_bram_addrb = seq[i];
            tick();
            if (i < 5) check($sformatf("feat_addr%0d", i), 64'(core_feat_addr), 64'(seq[i] >> 2));
            if (i >= 2) check($sformatf("feat_dout%0d", i - 2), 64'(feat_bram_dout), 64'(mem[4'(seq[i-2] >> 2)]));
        end

        // Reset mid-operation squashes the write presented on the same edge
        drive_write(3'b010, 20'h10, 32'h0000_1234);
        rst = 1'b1;
        tick();
        check("midrst_we", 64'(core_we), 64'd0);
        check("midrst_dbg", 64'({gat_debug_1, gat_debug_2}), 64'd0);
        check("midrst_feat", 64'({core_feat_addr, feat_bram_dout}), 64'd0);
        rst = 1'b0; load_ena = '0; load_wea = '0;
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
